// File: rtl/ex_alu_stage_if.sv
// ex_alu_stage_if: handshake and data bundle for the execute-stage ALU.
//
// Signals (names kept from the original port list):
//   ALUCtrl[3:0]     operation code from the ALU-control decoder
//   A, B[WIDTH-1:0]  operands (B is also the shift / LUI source)
//   Shamt[4:0]       shift amount
//   in_valid/in_ready     upstream handshake (transfer when both high)
//   Result, Zero, Overflow registered EX output buffer
//   out_valid/out_ready   downstream handshake toward EX/MEM
//
// Modports:
//   master - upstream/downstream side (drives ops, consumes results)
//   slave  - the ALU stage itself
interface ex_alu_stage_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       ALUCtrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       Shamt;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output ALUCtrl, A, B, Shamt, in_valid, out_ready,
    input  in_ready, Result, Zero, Overflow, out_valid
  );

  modport slave (
    input  ALUCtrl, A, B, Shamt, in_valid, out_ready,
    output in_ready, Result, Zero, Overflow, out_valid
  );
endinterface

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU with a registered output buffer and
// valid/ready handshakes on both sides.
//
// Ports:
//   clk    - pipeline clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - ex_alu_stage_if.slave (ALUCtrl, A, B, Shamt, in_valid,
//            in_ready, Result, Zero, Overflow, out_valid, out_ready)
//
// Logical/arithmetic ops complete in one cycle. Shifts (SLL/SRL/SRA) run
// one bit per cycle through a work register unless the FAST_SHIFT_EN
// macro is defined, in which case they are computed combinationally and
// the SHIFT state and counter are not built. Results are identical in
// both builds; only latency differs.
module ex_alu_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_alu_stage_if.slave    bus
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SRL  = 4'b0100,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_ADDU = 4'b1000,
    OP_SUBU = 4'b1001,
    OP_XOR  = 4'b1010,
    OP_SLTU = 4'b1011,
    OP_NOR  = 4'b1100,
    OP_SRA  = 4'b1101,
    OP_LUI  = 4'b1110
  } alu_op_e;

  alu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       shamt;

  assign op    = alu_op_e'(bus.ALUCtrl);
  assign a     = bus.A;
  assign b     = bus.B;
  assign shamt = bus.Shamt;

  // ---------------------------------------------------------------------
  // Single-cycle result path
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] comb_res;
  logic             comb_ovf;
  logic             is_shift;

  assign sum      = a + b;
  assign diff     = a - b;
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  always_comb begin
    comb_res = '0;
    comb_ovf = 1'b0;
    case (op)
      OP_AND:  comb_res = a & b;
      OP_OR:   comb_res = a | b;
      OP_XOR:  comb_res = a ^ b;
      OP_NOR:  comb_res = ~(a | b);
      OP_ADD: begin
        comb_res = sum;
        comb_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        comb_res = diff;
        comb_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: comb_res = sum;
      OP_SUBU: comb_res = diff;
      OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_LUI:  comb_res = WIDTH'({b[15:0], 16'h0000});
`ifdef FAST_SHIFT_EN
      OP_SLL:  comb_res = b << shamt;
      OP_SRL:  comb_res = b >> shamt;
      OP_SRA:  comb_res = $signed(b) >>> shamt;
`else
      // Only Shamt == 0 completes here; non-zero amounts go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA: comb_res = b;
`endif
      default: comb_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             buf_free;
  logic             accept;
  logic             wr;
  logic [WIDTH-1:0] wr_res;
  logic             wr_ovf;

  assign buf_free = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (wr) begin
      result_q    <= wr_res;
      zero_q      <= (wr_res == '0);
      ovf_q       <= wr_ovf;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.Result    = result_q;
  assign bus.Zero      = zero_q;
  assign bus.Overflow  = ovf_q;
  assign bus.out_valid = out_valid_q;

`ifdef FAST_SHIFT_EN
  // ---------------------------------------------------------------------
  // Every op completes in the accept cycle.
  // ---------------------------------------------------------------------
  assign bus.in_ready = buf_free;

  always_comb begin
    wr     = accept;
    wr_res = comb_res;
    wr_ovf = comb_ovf;
  end

`else
  // ---------------------------------------------------------------------
  // Iterative shifter: one bit per cycle through the work register.
  // ---------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  alu_op_e          sop_q, sop_d;
  logic [WIDTH-1:0] work_step;

  always_comb begin
    case (sop_q)
      OP_SLL:  work_step = work_q << 1;
      OP_SRL:  work_step = work_q >> 1;
      default: work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  assign bus.in_ready = (state_q == ST_IDLE) && buf_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      sop_q   <= OP_SLL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      sop_q   <= sop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    sop_d   = sop_q;
    wr      = 1'b0;
    wr_res  = comb_res;
    wr_ovf  = comb_ovf;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != 5'd0)) begin
            work_d  = b;
            cnt_d   = shamt;
            sop_d   = op;
            state_d = ST_SHIFT;
          end else begin
            wr = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q > 5'd1) begin
          work_d = work_step;
          cnt_d  = cnt_q - 5'd1;
        end else if (buf_free) begin
          // Final bit is applied straight into the output buffer; the
          // work register keeps its value since it is dead from here on.
          wr      = 1'b1;
          wr_res  = work_step;
          wr_ovf  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
`endif

endmodule
